// File: rtl/bvb_sched.sv
// rtl/bvb_sched.sv - banked vector buffer: one bank pointer sweeps image rows, serving per-channel column-id streams
// Each channel whose head id hits the row on ram_data pops it and queues the selected value in its output FIFO.
module bvb_sched #(
  parameter int CH_NUM      = 4,
  parameter int VAL_BITS    = 8,
  parameter int COL_ID_BITS = 6,
  parameter int SPLIT_BITS  = 2,
  parameter int ADDR_BITS   = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int SKIP_MODE   = 1,
  localparam int LOCAL_BITS   = COL_ID_BITS - SPLIT_BITS,
  localparam int VALS_PER_ROW = 2 ** LOCAL_BITS,
  localparam int ROW_BITS     = VALS_PER_ROW * VAL_BITS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          cfg_load,
  input  logic [ADDR_BITS-1:0]          cfg_base,
  input  logic [CH_NUM*COL_ID_BITS-1:0] id,
  input  logic [CH_NUM-1:0]             id_empty,
  output logic [CH_NUM-1:0]             id_rd,
  output logic                          ram_rd,
  output logic [ADDR_BITS-1:0]          ram_addr,
  input  logic [ROW_BITS-1:0]           ram_data,
  output logic [CH_NUM*VAL_BITS-1:0]    vec,
  output logic [CH_NUM-1:0]             vec_empty,
  input  logic [CH_NUM-1:0]             vec_rd,
  output logic [SPLIT_BITS-1:0]         cur_bank
);
  localparam int BANKS = 2 ** SPLIT_BITS;
  localparam int FA    = $clog2(FIFO_DEPTH);

  logic [ADDR_BITS-1:0]  r_base;
  logic [SPLIT_BITS-1:0] r_bank;
  logic [SPLIT_BITS-1:0] r_rd_bank;
  logic                  r_rd_v;
  logic [VAL_BITS-1:0]   r_mem [CH_NUM][FIFO_DEPTH];
  logic [FA:0]           r_wp  [CH_NUM];
  logic [FA:0]           r_rp  [CH_NUM];

  logic [SPLIT_BITS-1:0] w_head_bank [CH_NUM];
  logic [LOCAL_BITS-1:0] w_local     [CH_NUM];
  logic [CH_NUM-1:0]     w_full;
  logic [CH_NUM-1:0]     w_empty;
  logic [CH_NUM-1:0]     w_elig;
  logic [CH_NUM-1:0]     w_serve;
  logic [BANKS-1:0]      w_req;
  logic [SPLIT_BITS-1:0] w_next_bank;
  logic [SPLIT_BITS-1:0] w_cand;
  logic                  w_found;
  logic                  w_issue;

  // Serve is gated by rst and cfg_load so a discarded in-flight row never pops an id.
  always_comb begin
    w_req = '0;
    vec   = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      w_head_bank[c] = id[c*COL_ID_BITS + LOCAL_BITS +: SPLIT_BITS];
      w_local[c]     = id[c*COL_ID_BITS +: LOCAL_BITS];
      w_empty[c]     = (r_wp[c] == r_rp[c]);
      w_full[c]      = (r_wp[c][FA] != r_rp[c][FA]) && (r_wp[c][FA-1:0] == r_rp[c][FA-1:0]);
      w_elig[c]      = ~id_empty[c] & ~w_full[c];
      w_serve[c]     = r_rd_v & ~rst & ~cfg_load & w_elig[c] & (w_head_bank[c] == r_rd_bank);
      if (w_elig[c]) w_req[w_head_bank[c]] = 1'b1;
      vec[c*VAL_BITS +: VAL_BITS] = r_mem[c][r_rp[c][FA-1:0]];
    end
  end

  // Skip search walks banks after the current one; k == BANKS wraps back to the current bank last.
  always_comb begin
    w_next_bank = r_bank + 1'b1;
    w_cand      = r_bank;
    w_found     = 1'b0;
    if (SKIP_MODE != 0) begin
      w_next_bank = r_bank;
      for (int k = 1; k <= BANKS; k++) begin
        w_cand = r_bank + SPLIT_BITS'(k);
        if (!w_found && w_req[w_cand]) begin
          w_next_bank = w_cand;
          w_found     = 1'b1;
        end
      end
    end
    w_issue = ~rst & en & ~cfg_load & ((SKIP_MODE == 0) || (|w_req));
  end

  assign ram_rd    = w_issue;
  assign ram_addr  = r_base + ADDR_BITS'(r_bank);
  assign id_rd     = w_serve;
  assign vec_empty = w_empty;
  assign cur_bank  = r_rd_bank;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_base    <= '0;
      r_bank    <= '0;
      r_rd_v    <= 1'b0;
      r_rd_bank <= '0;
    end else begin
      r_rd_v <= w_issue;
      if (w_issue) r_rd_bank <= r_bank;
      if (cfg_load) begin
        r_base <= cfg_base;
        r_bank <= '0;
      end else if (w_issue) begin
        r_bank <= w_next_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < CH_NUM; c++) begin
      if (rst) begin
        r_wp[c] <= '0;
        r_rp[c] <= '0;
      end else begin
        if (w_serve[c]) r_wp[c] <= r_wp[c] + 1'b1;
        if (vec_rd[c] && !w_empty[c]) r_rp[c] <= r_rp[c] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < CH_NUM; c++) begin
      if (w_serve[c]) r_mem[c][r_wp[c][FA-1:0]] <= ram_data[int'(w_local[c])*VAL_BITS +: VAL_BITS];
    end
  end
endmodule
